// File: rtl/gemm_pkg.sv
// Shared types and helpers for the tiled GEMM sequencer: FSM state encoding,
// PE strobe bundle, and a log2 helper for power-of-two tile dimensions.
package gemm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_WRITE,
    ST_FIN
  } gemm_state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tile_strobe_t;

  function automatic int unsigned log2_pow2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((v >> i) == 1) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/gemm_valid_pipe.sv
// Delay line matching SRAM read latency: carries the per-issue PE strobes so
// they line up with read data; stalled cycles enter as empty bubbles.
module gemm_valid_pipe
  import gemm_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  tile_strobe_t strobe_i,
  input  logic         bubble_i,
  output tile_strobe_t strobe_o
);

  tile_strobe_t stage_q [Depth];
  tile_strobe_t stage_d [Depth];

  always_comb begin
    stage_d[0] = bubble_i ? '0 : strobe_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign strobe_o = stage_q[Depth-1];

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Tile-walking controller for the GEMM datapath: issues A/B read addresses per
// k, times PE strobes and drain, then writes one packed C tile with edge masks.
module gemm_tile_sequencer
  import gemm_pkg::*;
#(
  parameter int unsigned RowPar        = 4,
  parameter int unsigned ColPar        = 16,
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 32,
  parameter int unsigned MemLatency    = 1,
  parameter int unsigned PeLatency     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic                     stall_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     pe_valid_o,
  output logic                     pe_first_o,
  output logic                     pe_last_o,
  output logic [RowPar-1:0]        row_mask_o,
  output logic [ColPar-1:0]        col_mask_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int unsigned RowLog2     = log2_pow2(RowPar);
  localparam int unsigned ColLog2     = log2_pow2(ColPar);
  localparam int unsigned DrainCycles = MemLatency + PeLatency;
  localparam int unsigned DrainWidth  = 4;

  typedef logic [SizeAddrWidth-1:0] size_t;
  typedef logic [AddrWidth-1:0]     addr_t;

  gemm_state_e             state_q, state_d;
  size_t                   m_q, m_d, k_q, k_d, n_q, n_d;
  size_t                   m_tiles_q, m_tiles_d, n_tiles_q, n_tiles_d;
  size_t                   tile_m_q, tile_m_d, tile_n_q, tile_n_d;
  size_t                   kcnt_q, kcnt_d;
  addr_t                   a_base_q, a_base_d, b_base_q, b_base_d;
  addr_t                   c_addr_q, c_addr_d;
  logic [DrainWidth-1:0]   drain_q, drain_d;
  logic [RowPar-1:0]       row_mask_q, row_mask_d, row_mask_nxt;
  logic [ColPar-1:0]       col_mask_q, col_mask_d, col_mask_nxt;
  logic                    c_we_q, c_we_d, busy_q, busy_d;
  logic                    done_q, done_d, err_q, err_d;
  logic                    load_mask, clear_mask;
  logic                    last_k, last_tile_m, last_tile_n, issue;
  tile_strobe_t            strobe_in, strobe_out;

  assign last_k      = (kcnt_q == k_q - size_t'(1));
  assign last_tile_m = (tile_m_q == m_tiles_q - size_t'(1));
  assign last_tile_n = (tile_n_q == n_tiles_q - size_t'(1));
  assign issue       = (state_q == ST_STREAM) && !stall_i;

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    k_d        = k_q;
    n_d        = n_q;
    m_tiles_d  = m_tiles_q;
    n_tiles_d  = n_tiles_q;
    tile_m_d   = tile_m_q;
    tile_n_d   = tile_n_q;
    kcnt_d     = kcnt_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    c_addr_d   = c_addr_q;
    drain_d    = drain_q;
    row_mask_d = row_mask_q;
    col_mask_d = col_mask_q;
    err_d      = 1'b0;
    load_mask  = 1'b0;
    clear_mask = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (M_size_i == '0 || K_size_i == '0 || N_size_i == '0) begin
            err_d = 1'b1;
          end else begin
            m_d     = M_size_i;
            k_d     = K_size_i;
            n_d     = N_size_i;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        m_tiles_d = (m_q + size_t'(RowPar - 1)) >> RowLog2;
        n_tiles_d = (n_q + size_t'(ColPar - 1)) >> ColLog2;
        tile_m_d  = '0;
        tile_n_d  = '0;
        kcnt_d    = '0;
        a_base_d  = '0;
        b_base_d  = '0;
        c_addr_d  = '0;
        load_mask = 1'b1;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        if (!stall_i) begin
          if (last_k) begin
            kcnt_d  = '0;
            drain_d = '0;
            state_d = ST_DRAIN;
          end else begin
            kcnt_d = kcnt_q + size_t'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DrainWidth'(DrainCycles - 1)) begin
          state_d = ST_WRITE;
        end else begin
          drain_d = drain_q + DrainWidth'(1);
        end
      end
      ST_WRITE: begin
        if (last_tile_m && last_tile_n) begin
          clear_mask = 1'b1;
          state_d    = ST_FIN;
        end else begin
          // Running bases replace tile_m*K / tile_n*K products.
          if (last_tile_n) begin
            tile_n_d = '0;
            tile_m_d = tile_m_q + size_t'(1);
            a_base_d = a_base_q + addr_t'(k_q);
            b_base_d = '0;
          end else begin
            tile_n_d = tile_n_q + size_t'(1);
            b_base_d = b_base_q + addr_t'(k_q);
          end
          c_addr_d  = c_addr_q + addr_t'(1);
          load_mask = 1'b1;
          state_d   = ST_STREAM;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    for (int unsigned q = 0; q < RowPar; q++) begin
      row_mask_nxt[q] = ((tile_m_d << RowLog2) + size_t'(q)) < m_q;
    end
    for (int unsigned l = 0; l < ColPar; l++) begin
      col_mask_nxt[l] = ((tile_n_d << ColLog2) + size_t'(l)) < n_q;
    end
    if (load_mask) begin
      row_mask_d = row_mask_nxt;
      col_mask_d = col_mask_nxt;
    end else if (clear_mask) begin
      row_mask_d = '0;
      col_mask_d = '0;
    end

    c_we_d = (state_d == ST_WRITE);
    done_d = (state_d == ST_FIN);
    busy_d = (state_d == ST_LOAD) || (state_d == ST_STREAM) ||
             (state_d == ST_DRAIN) || (state_d == ST_WRITE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      m_q        <= '0;
      k_q        <= '0;
      n_q        <= '0;
      m_tiles_q  <= '0;
      n_tiles_q  <= '0;
      tile_m_q   <= '0;
      tile_n_q   <= '0;
      kcnt_q     <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_addr_q   <= '0;
      drain_q    <= '0;
      row_mask_q <= '0;
      col_mask_q <= '0;
      c_we_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      k_q        <= k_d;
      n_q        <= n_d;
      m_tiles_q  <= m_tiles_d;
      n_tiles_q  <= n_tiles_d;
      tile_m_q   <= tile_m_d;
      tile_n_q   <= tile_n_d;
      kcnt_q     <= kcnt_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      c_addr_q   <= c_addr_d;
      drain_q    <= drain_d;
      row_mask_q <= row_mask_d;
      col_mask_q <= col_mask_d;
      c_we_q     <= c_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign strobe_in.valid = 1'b1;
  assign strobe_in.first = (kcnt_q == '0);
  assign strobe_in.last  = last_k;

  gemm_valid_pipe #(
    .Depth(MemLatency)
  ) u_valid_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .strobe_i(strobe_in),
    .bubble_i(!issue),
    .strobe_o(strobe_out)
  );

  assign sram_a_addr_o = a_base_q + addr_t'(kcnt_q);
  assign sram_b_addr_o = b_base_q + addr_t'(kcnt_q);
  assign sram_c_addr_o = c_addr_q;
  assign sram_c_we_o   = c_we_q;
  assign pe_valid_o    = strobe_out.valid;
  assign pe_first_o    = strobe_out.first;
  assign pe_last_o     = strobe_out.last;
  assign row_mask_o    = row_mask_q;
  assign col_mask_o    = col_mask_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Scoreboard bench for gemm_tile_sequencer: expected PE beats and C writes are
// queued from an index-based model at job start and consumed by a monitor.
module tb_gemm_tile_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] m_size, k_size, n_size;
  logic        stall;
  logic [11:0] a_addr, b_addr, c_addr;
  logic        c_we, pe_valid, pe_first, pe_last, busy, done, err;
  logic [3:0]  row_mask;
  logic [15:0] col_mask;

  int checks;
  int failures;
  int cyc;
  int beats, writes, dones, errs;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        first;
    logic        last;
  } beat_t;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  rmask;
    logic [15:0] cmask;
  } wr_t;

  beat_t beat_q[$];
  wr_t   wr_q[$];
  logic [11:0] prev_a, prev_b;

  gemm_tile_sequencer #(
    .RowPar(4),
    .ColPar(16),
    .AddrWidth(12),
    .SizeAddrWidth(32),
    .MemLatency(1),
    .PeLatency(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .M_size_i(m_size),
    .K_size_i(k_size),
    .N_size_i(n_size),
    .stall_i(stall),
    .sram_a_addr_o(a_addr),
    .sram_b_addr_o(b_addr),
    .sram_c_addr_o(c_addr),
    .sram_c_we_o(c_we),
    .pe_valid_o(pe_valid),
    .pe_first_o(pe_first),
    .pe_last_o(pe_last),
    .row_mask_o(row_mask),
    .col_mask_o(col_mask),
    .busy_o(busy),
    .done_o(done),
    .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // With one cycle of memory latency, a PE beat belongs to the previous cycle's addresses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pe_valid) begin
        beats++;
        checks++;
        if (beat_q.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected: got a=%0d b=%0d, required no beat", prev_a, prev_b);
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          if ({prev_a, prev_b, pe_first, pe_last} !== {e.a, e.b, e.first, e.last}) begin
            failures++;
            $display("FAIL beat: got a=%0d b=%0d f=%b l=%b, required a=%0d b=%0d f=%b l=%b",
                     prev_a, prev_b, pe_first, pe_last, e.a, e.b, e.first, e.last);
          end
        end
      end
      if (c_we) begin
        writes++;
        checks++;
        if (wr_q.size() == 0) begin
          failures++;
          $display("FAIL write_unexpected: got addr=%0d, required no write", c_addr);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if ({c_addr, row_mask, col_mask} !== {w.addr, w.rmask, w.cmask}) begin
            failures++;
            $display("FAIL c_write: got addr=%0d rm=%h cm=%h, required addr=%0d rm=%h cm=%h",
                     c_addr, row_mask, col_mask, w.addr, w.rmask, w.cmask);
          end
        end
      end
      if (done) dones++;
      if (err) errs++;
    end
    prev_a = a_addr;
    prev_b = b_addr;
  end

  task automatic push_expected(input int unsigned m, input int unsigned k, input int unsigned n);
    int unsigned mt, nt, t;
    mt = (m + 3) / 4;
    nt = (n + 15) / 16;
    t  = 0;
    for (int unsigned tm = 0; tm < mt; tm++) begin
      for (int unsigned tn = 0; tn < nt; tn++) begin
        wr_t w;
        for (int unsigned kk = 0; kk < k; kk++) begin
          beat_t b;
          int unsigned av, bv;
          av = tm * k + kk;
          bv = tn * k + kk;
          b.a = av[11:0];
          b.b = bv[11:0];
          b.first = (kk == 0);
          b.last  = (kk == k - 1);
          beat_q.push_back(b);
        end
        w.addr = t[11:0];
        for (int unsigned q = 0; q < 4; q++) w.rmask[q] = (tm * 4 + q < m);
        for (int unsigned l = 0; l < 16; l++) w.cmask[l] = (tn * 16 + l < n);
        wr_q.push_back(w);
        t++;
      end
    end
  endtask

  task automatic run_job(input int unsigned m, input int unsigned k, input int unsigned n,
                         input int unsigned stall_at, input int unsigned stall_len,
                         input int unsigned exp_lat, input string name);
    int s;
    int lat;
    bit got;
    push_expected(m, k, n);
    @(posedge clk); #1;
    start = 1'b1; m_size = m; k_size = k; n_size = n;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    m_size = $urandom; k_size = $urandom; n_size = $urandom;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy: got %b, required 1", name, busy);
    end
    got = 0;
    lat = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      stall = (stall_len > 0) && (cyc >= s + int'(stall_at)) && (cyc < s + int'(stall_at + stall_len));
      @(negedge clk);
      if (stall) begin
        checks++;
        if (a_addr !== 12'(stall_at - 2)) begin
          failures++;
          $display("FAIL %s_stall_hold: got a=%0d, required %0d", name, a_addr, stall_at - 2);
        end
      end
      if (done) begin
        got = 1;
        lat = cyc - s;
      end else begin
        @(posedge clk); #1;
      end
    end
    stall = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout: got no done, required done within 2000 cycles", name);
    end else if (lat != int'(exp_lat)) begin
      failures++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL %s_after_done: got busy=%b done=%b, required 0 0", name, busy, done);
    end
    checks++;
    if (beat_q.size() != 0 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL %s_leftover: got beats=%0d writes=%0d pending, required 0 0",
               name, beat_q.size(), wr_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    m_size = '0; k_size = '0; n_size = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_addr, b_addr, c_addr, c_we, pe_valid, pe_first, pe_last, row_mask, col_mask,
         busy, done, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got a=%0d b=%0d c=%0d rm=%h cm=%h busy=%b, required all 0",
               a_addr, b_addr, c_addr, row_mask, col_mask, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_tile();
    int b0;
    b0 = beats;
    run_job(4, 64, 16, 0, 0, 70, "single");
    checks++;
    if (beats - b0 != 64) begin
      failures++;
      $display("FAIL single_beats: got %0d, required 64", beats - b0);
    end
  endtask

  task automatic test_multi_tile();
    int w0;
    w0 = writes;
    run_job(32, 32, 32, 0, 0, 578, "multi");
    checks++;
    if (writes - w0 != 16) begin
      failures++;
      $display("FAIL multi_writes: got %0d, required 16", writes - w0);
    end
  endtask

  task automatic test_edge_masks();
    run_job(5, 64, 10, 0, 0, 138, "edge");
  endtask

  task automatic test_zero_dim();
    int unsigned dims [3][3];
    dims = '{'{0, 64, 16}, '{4, 0, 16}, '{4, 64, 0}};
    for (int p = 0; p < 3; p++) begin
      int e0, w0, d0;
      bit busy_seen;
      @(posedge clk); #1;
      start = 1'b1; m_size = dims[p][0]; k_size = dims[p][1]; n_size = dims[p][2];
      @(posedge clk); #1;
      start = 1'b0;
      e0 = errs; w0 = writes; d0 = dones;
      @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
        failures++;
        $display("FAIL zero_err_pulse[%0d]: got %b, required 1", p, err);
      end
      busy_seen = busy;
      repeat (10) begin
        @(negedge clk);
        busy_seen |= busy;
      end
      checks++;
      if (errs - e0 != 1 || writes != w0 || dones != d0 || busy_seen) begin
        failures++;
        $display("FAIL zero_side_effects[%0d]: got errs=%0d writes=%0d dones=%0d busy=%b, required 1 0 0 0",
                 p, errs - e0, writes - w0, dones - d0, busy_seen);
      end
    end
    run_job(4, 64, 16, 0, 0, 70, "after_err");
  endtask

  task automatic test_stall();
    int b0;
    b0 = beats;
    run_job(4, 64, 16, 12, 3, 73, "stall");
    checks++;
    if (beats - b0 != 64) begin
      failures++;
      $display("FAIL stall_beats: got %0d, required 64", beats - b0);
    end
  endtask

  task automatic test_reset_mid();
    int s, w0, d0;
    bit hit;
    push_expected(32, 32, 32);
    @(posedge clk); #1;
    start = 1'b1; m_size = 32; k_size = 32; n_size = 32;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (cyc == s + 190) hit = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL rstmid_reach: got cycle %0d, required %0d", cyc - s, 190);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_addr, b_addr, c_addr, c_we, pe_valid, pe_first, pe_last, row_mask, col_mask,
         busy, done, err} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: got a=%0d b=%0d c=%0d rm=%h cm=%h busy=%b, required all 0",
               a_addr, b_addr, c_addr, row_mask, col_mask, busy);
    end
    beat_q.delete();
    wr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = writes; d0 = dones;
    repeat (60) @(negedge clk);
    checks++;
    if (writes != w0 || dones != d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_quiet: got writes=%0d dones=%0d busy=%b, required 0 0 0",
               writes - w0, dones - d0, busy);
    end
    run_job(4, 64, 16, 0, 0, 70, "restart");
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    beats = 0; writes = 0; dones = 0; errs = 0;
    prev_a = '0; prev_b = '0;
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_edge_masks();
    test_zero_dim();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
